mcu_irq_ctrl: RTL

Interrupt aggregator and scheduler between core-side event sources (HID, SD card, OSD, floppy/1541 status) and the 8-bit interrupt vector that the system-control block reports to the MCU. It does four things:
- Latches per-source events into a pending register.
- Applies an MCU-programmable mask.
- Rate-limits re-assertion after each acknowledge.
- Clears pending bits from the system-control ack vector.
It sits directly upstream of the system-control int_in/int_ack pair.

---
 rtl/mcu_if_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/mcu_irq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/mcu_if_pkg.sv
// Shared definitions for the MCU interrupt path.
//   IRQ_* : bit positions of the core-side interrupt sources in the vector
//   IRQ_W : width of the interrupt / ack vector seen by system control
//   HOLDOFF_DEFAULT : default re-assertion holdoff after an acknowledge
package mcu_if_pkg;

  localparam int IRQ_W = 8;

  localparam int IRQ_COLDBOOT = 0;
  localparam int IRQ_HID      = 1;
  localparam int IRQ_SDC      = 2;
  localparam int IRQ_OSD      = 3;
  localparam int IRQ_FDD      = 4;

  localparam logic [15:0] HOLDOFF_DEFAULT = 16'd1000;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-bit-first priority encoder.
//   vec : request vector
//   id  : index of the lowest set bit of vec (0 when vec is empty)
//   any : OR of vec
module irq_prio_enc
  import mcu_if_pkg::*;
(
  input  logic [IRQ_W-1:0] vec,
  output logic [2:0]       id,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last writer.
  always_comb begin
    id = '0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (vec[i]) id = 3'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/mcu_irq_ctrl.sv
// Interrupt aggregator feeding the system-control int_in/int_ack pair.
// Latches source events into a pending register, gates them with an
// MCU-written mask and suppresses the vector for HOLDOFF cycles after each
// nonzero acknowledge.
//   clk, reset   : system clock, synchronous active-high reset
//   src          : raw source pulses/levels (per-bit selected by EDGE_SRC)
//   mask_wr      : strobe, loads mask_in into the enable mask
//   mask_in      : new enable mask (1 = enabled)
//   int_ack      : ack vector, a set bit clears that pending bit
//   int_vec      : masked pending vector (zero while holdoff runs)
//   int_any      : OR of int_vec
//   int_id       : lowest set bit index of int_vec
//   overflow     : sticky, event hit an already-pending bit
//   holdoff_busy : holdoff counter running
module mcu_irq_ctrl
  import mcu_if_pkg::*;
#(
  parameter int          N        = 8,
  parameter logic [7:0]  EDGE_SRC = 8'hFF,
  parameter logic [15:0] HOLDOFF  = HOLDOFF_DEFAULT,
  parameter logic [7:0]  MASK_RST = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     src,
  input  logic             mask_wr,
  input  logic [IRQ_W-1:0] mask_in,
  input  logic [IRQ_W-1:0] int_ack,
  output logic [IRQ_W-1:0] int_vec,
  output logic             int_any,
  output logic [2:0]       int_id,
  output logic [IRQ_W-1:0] overflow,
  output logic             holdoff_busy
);

  // Bits at or above N do not exist; they stay 0 and are ignored on ack.
  localparam logic [IRQ_W-1:0] VALID = IRQ_W'((9'h1 << N) - 9'h1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [IRQ_W-1:0] src_w, src_q, evt, ack_v;
  logic [IRQ_W-1:0] pending, pending_next;
  logic [IRQ_W-1:0] overflow_next;
  logic [IRQ_W-1:0] mask, mask_next;
  logic [IRQ_W-1:0] vec_next;
  logic [0:0]       state, state_next;
  logic [15:0]      cnt, cnt_next;
  logic [2:0]       id_next;
  logic             any_next;

  always_comb begin
    src_w        = '0;
    src_w[N-1:0] = src;
  end

  assign ack_v = int_ack & VALID;
  assign evt   = ((EDGE_SRC & src_w & ~src_q) | (~EDGE_SRC & src_w)) & VALID;

  // A same-cycle event beats the ack, so the bit stays pending.
  assign pending_next  = (pending & ~ack_v) | evt;
  assign overflow_next = (overflow & ~ack_v) | (evt & pending & ~ack_v);
  assign mask_next     = mask_wr ? mask_in : mask;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if ((ack_v != '0) && (HOLDOFF != 16'd0)) begin
          state_next = ST_HOLD;
          cnt_next   = HOLDOFF - 16'd1;
        end
      end
      ST_HOLD: begin
        if (ack_v != '0)       cnt_next   = HOLDOFF - 16'd1;
        else if (cnt == 16'd0) state_next = ST_IDLE;
        else                   cnt_next   = cnt - 16'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so vec/any/id move together.
  assign vec_next = (state_next == ST_IDLE) ? (pending_next & mask_next) : '0;

  irq_prio_enc u_prio_enc (
    .vec (vec_next),
    .id  (id_next),
    .any (any_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q        <= '0;
      pending      <= '0;
      overflow     <= '0;
      mask         <= MASK_RST;
      state        <= ST_IDLE;
      cnt          <= '0;
      int_vec      <= '0;
      int_any      <= 1'b0;
      int_id       <= '0;
      holdoff_busy <= 1'b0;
    end else begin
      src_q        <= src_w;
      pending      <= pending_next;
      overflow     <= overflow_next;
      mask         <= mask_next;
      state        <= state_next;
      cnt          <= cnt_next;
      int_vec      <= vec_next;
      int_any      <= any_next;
      int_id       <= id_next;
      holdoff_busy <= (state_next == ST_HOLD);
    end
  end

endmodule
